shift_seq_ctrl: RTL
===================

// Module: shift_seq_ctrl
// PURPOSE
//   Sequencer for the 8-bit shift/increment register. Takes one command per handshake
//   (op, seed, count), drives the register for count+1 back-to-back iterations,
//   feeding its output back as its input each time. Returns the final value on a
//   valid/ready response channel. Sits between the command source and the register.
// PARAMETERS
//   DATA_W  8  data width; must match the register
//   CNT_W   4  width of cmd_count; iterations = cmd_count+1, range 1..2**CNT_W
// PORTS
//   clk          in   1       single clock; all logic on posedge clk
//   reset_n      in   1       asynchronous active-low reset
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       1 only in IDLE
//   cmd_op       in   2       00 LOAD, 01 SHR1, 10 SHL1, 11 INC (register select code)
//   cmd_data     in   DATA_W  seed value for the first iteration
//   cmd_count    in   CNT_W   iterations minus one
//   rsp_valid    out  1       result available
//   rsp_ready    in   1       result consumed
//   rsp_data     out  DATA_W  final register value
//   sr_data_in   out  DATA_W  to register data_in
//   sr_select    out  2       to register select
//   sr_load      out  1       to register load; 0 clears the register at the next edge
//   sr_reset     out  1       to register reset (active-high)
//   sr_data_out  in   DATA_W  from register data_out; registered, valid 1 cycle after drive
//   abort        in   1       present only with SHIFT_SEQ_ABORT_EN
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous): state=IDLE. Counter, op and seed registers = 0.
//     rsp_valid=0, rsp_data=0. sr_* = 0, except sr_reset = ~reset_n (combinational).
//   FSM IDLE -> RUN -> CAPT -> RESP -> IDLE.
//   IDLE: cmd_ready=1, sr_load=0. On cmd_valid: latch op, data and count into
//     remaining; go to RUN. No new command is accepted outside IDLE.
//   RUN: sr_load=1 and sr_select=op. First cycle: sr_data_in=latched seed.
//     Later cycles: sr_data_in=sr_data_out (feedback). One iteration per cycle.
//     remaining decrements each cycle. Leave for CAPT in the cycle with remaining==0.
//   CAPT: sr_load=0, so the register clears at the edge. rsp_data <= sr_data_out.
//     Go to RESP.
//   RESP: rsp_valid=1 and rsp_data held stable. On rsp_ready: go to IDLE.
//     In the same edge rsp_valid goes 0.
//   Latency: rsp_valid rises cmd_count+2 edges after the accept edge. With rsp_ready
//     tied high, the next command is accepted no earlier than 1 cycle after the
//     response handshake.
//   Arithmetic: done by the register, mod 2**DATA_W. INC wraps 0xFF->0x00.
//     SHR and SHL fill with 0.
//   Outside RUN: sr_select=00 and sr_data_in=0.
//   Count: cmd_count=0 gives 1 iteration. cmd_count=all-ones gives 2**CNT_W iterations.
//     The counter never wraps below 0.
//   reset_n low mid-RUN/CAPT/RESP: immediate IDLE, response dropped, register cleared.
// CONFIGURATION
//   SHIFT_SEQ_ABORT_EN defined:
//     - abort port exists.
//     - abort=1 in RUN or CAPT: next state IDLE, sr_reset=1 for that one cycle,
//       no response.
//     - Ignored in IDLE and RESP.
//   Not defined: no abort port. A command always runs to completion.
// STRUCTURE
//   shift_seq_pkg: op encodings (OP_LOAD/OP_SHR/OP_SHL/OP_INC) and the state enum
//     (S_IDLE, S_RUN, S_CAPT, S_RESP). Shared with the command-source and bench code.
//   Sub-module shift_seq_iter_cnt: CNT_W down-counter.
//     Inputs: load, value, dec. Output: zero flag.
//   The FSM and muxing live in the top module.
// TESTING
//   Connect the real shift register to sr_*. A scoreboard models op^(count+1).
//   INC, data=0xFE, count=2 -> rsp_data=0x01 (wraps); rsp_valid 4 edges after accept.
//   SHL, data=0x01, count=6 -> rsp_data=0x80. SHR, data=0x80, count=15 -> rsp_data=0x00.
//   LOAD, data=0xA5, count=0 -> rsp_data=0xA5; rsp_valid 2 edges after accept;
//     sr_load high exactly 1 cycle.
//   rsp_ready low for 5 cycles -> rsp_valid and rsp_data=0x80 stable, cmd_ready=0.
//     Then handshake, then back-to-back commands.
//   reset_n pulsed low in the 3rd RUN cycle -> immediately: state IDLE, rsp_valid=0,
//     sr_reset=1. Next command, INC 0x00 count 0 -> rsp_data=0x01.
//   With SHIFT_SEQ_ABORT_EN: abort in RUN -> sr_reset=1 for 1 cycle, no rsp_valid,
//     cmd_ready=1 next cycle.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift/increment register sequencer: register
// select codes and FSM state constants.
package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_INC  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_CAPT = 2'd2;
  localparam state_t S_RESP = 2'd3;

endpackage

// File: rtl/shift_seq_iter_cnt.sv
// Iteration down-counter: loaded with iterations-minus-one, stops at zero.
module shift_seq_iter_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving the shift/increment register for count+1 feedback iterations.
// Optional abort input is built when SHIFT_SEQ_ABORT_EN is defined.
//
//   state  | meaning
//   S_IDLE | ready for a command, register held clear
//   S_RUN  | one register iteration per cycle, output fed back
//   S_CAPT | final register value captured into rsp_data
//   S_RESP | response offered until rsp_ready
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] sr_data_in,
  output logic [1:0]        sr_select,
  output logic              sr_load,
  output logic              sr_reset,
  input  logic [DATA_W-1:0] sr_data_out
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic              abort
`endif
);

  state_t            state, state_nxt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] seed_q;
  logic              first_q;
  logic              accept;
  logic              cnt_zero;
  logic              abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = abort && ((state == S_RUN) || (state == S_CAPT));
`else
  assign abort_hit = 1'b0;
`endif

  assign accept = (state == S_IDLE) && cmd_valid;

  shift_seq_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .value   (cmd_count),
    .dec     (state == S_RUN),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_valid) state_nxt = S_RUN;
      S_RUN: begin
        if (abort_hit)     state_nxt = S_IDLE;
        else if (cnt_zero) state_nxt = S_CAPT;
      end
      S_CAPT: state_nxt = abort_hit ? S_IDLE : S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      seed_q   <= '0;
      first_q  <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= cmd_op;
        seed_q  <= cmd_data;
        first_q <= 1'b1;
      end else if (state == S_RUN) begin
        first_q <= 1'b0;
      end
      if ((state == S_CAPT) && !abort_hit) rsp_data <= sr_data_out;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // Register clears whenever load is low, so it only holds a value during RUN.
  assign sr_load    = (state == S_RUN);
  assign sr_select  = (state == S_RUN) ? op_q : 2'b00;
  assign sr_data_in = (state != S_RUN) ? '0 : (first_q ? seed_q : sr_data_out);
  assign sr_reset   = ~reset_n | abort_hit;

endmodule
